// File: rtl/arbitro_memoria.sv
// Two-port arbiter in front of a single-port data memory: grants one requester at a time.
// Latency: req sampled at grant edge N -> one memory access cycle -> ack pulse in the cycle after edge N+2.
// Backpressure: a requester holds req/fields until its ack; requests seen outside INACTIVO simply wait.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req*/we*/dir*/dato_esc*  request from requester 0 / 1 (write flag, word address, write data)
//   ack*/dato_lec*/err*   one-cycle completion pulse with read data and out-of-range flag
//   mem_dir/mem_we/mem_dato_esc/mem_dato_lec  data-memory access port (combinational read data)
// Optional feature: define ROUND_ROBIN_EN to alternate grants between simultaneous requesters;
// without it requester 0 always wins a tie.
module arbitro_memoria #(
    parameter int PROF = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] dir0,
    input  logic [31:0] dir1,
    input  logic [31:0] dato_esc0,
    input  logic [31:0] dato_esc1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] dato_lec0,
    output logic [31:0] dato_lec1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_dir,
    output logic        mem_we,
    output logic [31:0] mem_dato_esc,
    input  logic [31:0] mem_dato_lec
);

    localparam logic [31:0] PROF_W = 32'(PROF);

    typedef enum logic [1:0] {
        INACTIVO  = 2'd0,
        ACCESO    = 2'd1,
        RESPUESTA = 2'd2
    } estado_t;

    estado_t estado, estado_sig;

    // Winner selection for the current cycle
    logic        gana1;
    logic        sel_we;
    logic [31:0] sel_dir;
    logic [31:0] sel_dato;
    logic        concede;

    // Transaction fields frozen at the grant edge
    logic        lat_we;
    logic        lat_port;
    logic        lat_fuera;
    logic [31:0] lat_dir;
    logic [31:0] lat_dato;
    logic [31:0] lat_lec;

    // Next values of the registered outputs
    logic        mem_we_sig;
    logic        ack0_sig;
    logic        ack1_sig;
    logic        err0_sig;
    logic        err1_sig;
    logic [31:0] dato_lec0_sig;
    logic [31:0] dato_lec1_sig;

`ifdef ROUND_ROBIN_EN
    // Port served by the most recent grant; reset value 1 makes port 0 win the first tie.
    logic ultimo;

    always_ff @(posedge clk) begin
        if (reset) begin
            ultimo <= 1'b1;
        end else if (concede) begin
            ultimo <= gana1;
        end
    end

    // On a tie, the port that was not served last wins.
    assign gana1 = req1 && (!req0 || !ultimo);
`else
    assign gana1 = req1 && !req0;
`endif

    assign concede  = (estado == INACTIVO) && (req0 || req1);
    assign sel_we   = gana1 ? we1       : we0;
    assign sel_dir  = gana1 ? dir1      : dir0;
    assign sel_dato = gana1 ? dato_esc1 : dato_esc0;

    // Address and write data are only presented during the single access cycle.
    assign mem_dir      = (estado == ACCESO) ? lat_dir  : '0;
    assign mem_dato_esc = (estado == ACCESO) ? lat_dato : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= INACTIVO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig    = estado;
        mem_we_sig    = 1'b0;
        ack0_sig      = 1'b0;
        ack1_sig      = 1'b0;
        err0_sig      = 1'b0;
        err1_sig      = 1'b0;
        dato_lec0_sig = '0;
        dato_lec1_sig = '0;
        case (estado)
            INACTIVO: begin
                if (req0 || req1) begin
                    estado_sig = ACCESO;
                    // Registered so it is high exactly during the ACCESO cycle.
                    mem_we_sig = sel_we && (sel_dir < PROF_W);
                end
            end
            ACCESO: begin
                estado_sig = RESPUESTA;
            end
            RESPUESTA: begin
                estado_sig = INACTIVO;
                if (lat_port) begin
                    ack1_sig      = 1'b1;
                    err1_sig      = lat_fuera;
                    dato_lec1_sig = lat_lec;
                end else begin
                    ack0_sig      = 1'b1;
                    err0_sig      = lat_fuera;
                    dato_lec0_sig = lat_lec;
                end
            end
            default: begin
                estado_sig = INACTIVO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            dato_lec0 <= '0;
            dato_lec1 <= '0;
            lat_we    <= 1'b0;
            lat_port  <= 1'b0;
            lat_fuera <= 1'b0;
            lat_dir   <= '0;
            lat_dato  <= '0;
            lat_lec   <= '0;
        end else begin
            mem_we    <= mem_we_sig;
            ack0      <= ack0_sig;
            ack1      <= ack1_sig;
            err0      <= err0_sig;
            err1      <= err1_sig;
            dato_lec0 <= dato_lec0_sig;
            dato_lec1 <= dato_lec1_sig;
            if (concede) begin
                lat_we    <= sel_we;
                lat_port  <= gana1;
                lat_dir   <= sel_dir;
                lat_dato  <= sel_dato;
                lat_fuera <= (sel_dir >= PROF_W);
            end
            if (estado == ACCESO) begin
                // Writes and out-of-range accesses report zero read data.
                lat_lec <= (lat_we || lat_fuera) ? '0 : mem_dato_lec;
            end
        end
    end

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameter PROF, default 32, number of data memory words; valid addresses are 0..PROF-1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  transaction request, requester 0 / requester 1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 dir0, dir1  input  32 each  word address.
REQ-007 dato_esc0, dato_esc1  input  32 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 dato_lec0, dato_lec1  output  32 each  read data, valid while the matching ack is high.
REQ-010 err0, err1  output  1 each  address out of range, valid while the matching ack is high.
REQ-011 mem_dir  output  32  address to the data memory.
REQ-012 mem_we  output  1  write enable to the data memory (drives MemWrite).
REQ-013 mem_dato_esc  output  32  write data to the data memory.
REQ-014 mem_dato_lec  input  32  combinational read data from the data memory.

Function
REQ-015 The block SHALL implement a three-state FSM: INACTIVO, ACCESO, RESPUESTA.
REQ-016 INACTIVO: if any req is high at a clock edge, the FSM SHALL latch the winner's we/dir/dato_esc and its port index, then go to ACCESO; otherwise it SHALL stay in INACTIVO.
REQ-017 ACCESO: the block SHALL drive mem_dir and mem_dato_esc from the latched values for exactly one cycle, capture mem_dato_lec at the closing edge, and go to RESPUESTA.
REQ-018 mem_we SHALL be registered, high only in ACCESO, and only for a write whose address is below PROF.
REQ-019 Outside ACCESO, mem_we, mem_dir and mem_dato_esc SHALL be 0.
REQ-020 RESPUESTA: the block SHALL pulse only the granted port's ack for one cycle, present dato_lec (read) or 0 (write) plus err, then return to INACTIVO.
REQ-021 Latency: a req sampled at edge N SHALL yield ack high in the cycle after edge N+2; throughput is one transaction per 3 cycles.
REQ-022 Handshake: a requester holds req, we, dir and dato_esc stable until it samples its ack; it deasserts req in the following cycle.
REQ-023 A req still high in INACTIVO SHALL be treated as a new request.
REQ-024 Request fields are latched at the grant edge; later changes to them SHALL NOT affect the transaction in flight.
REQ-025 An address of PROF or more SHALL suppress mem_we, return dato_lec = 0, and set err high with ack.
REQ-026 Requests arriving in ACCESO or RESPUESTA SHALL wait; they are never dropped or merged.
REQ-027 A non-granted port's ack, err and dato_lec SHALL be 0.

Reset
REQ-028 While reset is high at an edge, the FSM SHALL enter INACTIVO.
REQ-029 Reset SHALL set all outputs to 0 and set the last-served register to port 1.
REQ-030 A reset during ACCESO or RESPUESTA SHALL abort the transaction: no ack is issued, and mem_we is 0 from the next cycle; the requester reissues.

Configuration
REQ-031 With ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not served last; the last-served register updates at each grant.
REQ-032 Without ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests, the last-served register SHALL be absent, and port 1 may starve.

Verification
REQ-033 Port 0 write: req0=1, we0=1, dir0=5, dato_esc0=0xDEADBEEF -> mem_we=1 with mem_dir=5 for exactly one cycle; ack0 pulses 2 cycles after grant; err0=0.
REQ-034 Port 1 read back: req1=1, we1=0, dir1=5 -> ack1 pulses with dato_lec1=0xDEADBEEF; ack0 stays 0.
REQ-035 Both ports request continuously under ROUND_ROBIN_EN -> grants alternate 0,1,0,1 starting with port 0; without the macro -> only port 0 is served.
REQ-036 Out-of-range write: dir0=32 -> mem_we stays 0; ack0=1 with err0=1 and dato_lec0=0; a later read of word 0 returns its prior value unchanged.
REQ-037 Reset mid-transaction: assert reset during ACCESO of a write -> no ack, mem_we=0 the next cycle, all outputs 0, FSM in INACTIVO.
